// File: rtl/instr_fetch.sv
// instr_fetch: PC register, next-PC selection and instruction fetch sequencer.
// Issues one word request per instruction over a req/ready handshake, holds the
// fetched word for decode and then advances the PC to PC+4, a taken branch
// target or a JALR target. A redirect target that is not word aligned sends the
// PC to TRAP_PC and raises a single-cycle misalign_err.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC   = 32'h0000_0100,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_err
);

    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JALR   = 2'b10;

    typedef enum logic [1:0] {
        ST_RST   = 2'b00,
        ST_FETCH = 2'b01,
        ST_ISSUE = 2'b10
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] instr_q;

    logic        fetch_done;
    logic        issue_done;

    logic [31:0] seq_pc;
    logic [31:0] branch_tgt;
    logic [31:0] jalr_tgt;
    logic        redirect;
    logic [31:0] sel_tgt;
    logic        tgt_misaligned;
    logic [31:0] next_pc;

    // Only redirected targets can be misaligned; PC+4 from an aligned PC never is.
    function automatic logic is_misaligned(input logic redir, input logic [31:0] tgt);
        return redir && (tgt[1:0] != 2'b00);
    endfunction

    // Next-PC candidates and selection, all modulo 2^32.
    always_comb begin
        seq_pc     = pc_q + 32'd4;
        branch_tgt = pc_q + imm;
        jalr_tgt   = alu_result & 32'hFFFF_FFFE;
        redirect   = 1'b0;
        sel_tgt    = seq_pc;
        case (pc_src)
            PC_SRC_BRANCH: begin
                if (branch && alu_zero) begin
                    redirect = 1'b1;
                    sel_tgt  = branch_tgt;
                end
            end
            PC_SRC_JALR: begin
                redirect = 1'b1;
                sel_tgt  = jalr_tgt;
            end
            default: begin
                redirect = 1'b0;
                sel_tgt  = seq_pc;
            end
        endcase
        tgt_misaligned = is_misaligned(redirect, sel_tgt);
        next_pc        = tgt_misaligned ? TRAP_PC : sel_tgt;
    end

    // Sequencer state register; reset parks in RST for one cycle after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake strobes; stall only matters in ISSUE.
    always_comb begin
        state_nxt  = state;
        fetch_done = 1'b0;
        issue_done = 1'b0;
        case (state)
            ST_RST: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    fetch_done = 1'b1;
                    state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    issue_done = 1'b1;
                    state_nxt  = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_RST;
            end
        endcase
    end

    // PC advances only when an issued instruction leaves ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (issue_done) begin
            pc_q <= next_pc;
        end
    end

    // Instruction word is captured on handshake and held until the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
        end else if (fetch_done) begin
            instr_q <= imem_rdata;
        end
    end

    // Outputs: request and valid decode straight from state; error pulse is combinational.
    always_comb begin
        imem_req     = (state == ST_FETCH);
        imem_addr    = pc_q;
        instr_valid  = (state == ST_ISSUE);
        instr        = instr_q;
        pc           = pc_q;
        pc_plus4     = seq_pc;
        misalign_err = issue_done && tgt_misaligned;
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  pc_src;
    logic        branch;
    logic        alu_zero;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_err;

    instr_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .pc_src       (pc_src),
        .branch       (branch),
        .alu_zero     (alu_zero),
        .imm          (imm),
        .alu_result   (alu_result),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: architectural PC and the held instruction word.
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    typedef struct {
        logic [31:0] start;
        logic [1:0]  src;
        logic        br;
        logic        z;
        logic [31:0] im;
        logic [31:0] alu;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference next PC: returns {error, new_pc}.
    function automatic logic [32:0] ref_next(input logic [31:0] cur, input logic [1:0] src,
                                             input logic br, input logic z,
                                             input logic [31:0] im, input logic [31:0] alu);
        logic [31:0] t;
        bit jump;
        jump = 0;
        t = cur + 32'd4;
        if (src == 2'b01 && br && z) begin
            jump = 1;
            t = cur + im;
        end else if (src == 2'b10) begin
            jump = 1;
            t = {alu[31:1], 1'b0};
        end
        if (jump && (t % 4) != 0) return {1'b1, 32'h0000_0100};
        return {1'b0, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in FETCH; holds ready low for wait_cyc cycles then delivers word.
    task automatic fetch(input logic [31:0] word, input int wait_cyc);
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_valid", {31'd0, instr_valid}, 32'd0);
        chk("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < wait_cyc; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            tick();
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, m_pc);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        tick();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        m_instr = word;
        chk("issue_valid", {31'd0, instr_valid}, 32'd1);
        chk("issue_req", {31'd0, imem_req}, 32'd0);
        chk("issue_instr", instr, m_instr);
        chk("issue_pc", pc, m_pc);
        chk("issue_pc4", pc_plus4, m_pc + 32'd4);
    endtask

    // Entered in ISSUE; stalls nstall cycles, then leaves ISSUE with the given selection.
    task automatic issue(input logic [1:0] src, input logic br, input logic z,
                         input logic [31:0] im, input logic [31:0] alu, input int nstall);
        logic [32:0] r;
        pc_src = src; branch = br; alu_zero = z; imm = im; alu_result = alu;
        for (int i = 0; i < nstall; i++) begin
            stall = 1'b1;
            #1;
            chk("stall_err", {31'd0, misalign_err}, 32'd0);
            tick();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_pc", pc, m_pc);
            chk("stall_instr", instr, m_instr);
        end
        stall = 1'b0;
        r = ref_next(m_pc, src, br, z, im, alu);
        #1;
        chk("issue_err", {31'd0, misalign_err}, {31'd0, r[32]});
        tick();
        m_pc = r[31:0];
        chk("next_addr", imem_addr, m_pc);
        chk("next_req", {31'd0, imem_req}, 32'd1);
        chk("next_valid", {31'd0, instr_valid}, 32'd0);
        chk("next_err", {31'd0, misalign_err}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; pc_src = 2'b00; branch = 1'b0; alu_zero = 1'b0;
        imm = '0; alu_result = '0; imem_ready = 1'b0; imem_rdata = '0;

        vecs[0]  = '{32'h10,       2'b01, 1'b1, 1'b1, 32'h20,       32'h0,   32'h30,  1'b0};
        vecs[1]  = '{32'h10,       2'b01, 1'b1, 1'b0, 32'h20,       32'h0,   32'h14,  1'b0};
        vecs[2]  = '{32'h10,       2'b10, 1'b0, 1'b0, 32'h0,        32'h207, 32'h100, 1'b1};
        vecs[3]  = '{32'h10,       2'b10, 1'b0, 1'b0, 32'h0,        32'h201, 32'h200, 1'b0};
        vecs[4]  = '{32'h10,       2'b11, 1'b1, 1'b1, 32'h20,       32'h0,   32'h14,  1'b0};
        vecs[5]  = '{32'h10,       2'b00, 1'b1, 1'b1, 32'h20,       32'h0,   32'h14,  1'b0};
        vecs[6]  = '{32'h100,      2'b01, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0,  32'hF8,  1'b0};
        vecs[7]  = '{32'h40,       2'b01, 1'b1, 1'b1, 32'h22,       32'h0,   32'h100, 1'b1};
        vecs[8]  = '{32'hFFFF_FFFC, 2'b00, 1'b0, 1'b0, 32'h0,       32'h0,   32'h0,   1'b0};
        vecs[9]  = '{32'h40,       2'b01, 1'b0, 1'b1, 32'h8,        32'h0,   32'h44,  1'b0};
        vecs[10] = '{32'h80,       2'b10, 1'b0, 1'b0, 32'h0,        32'h1,   32'h0,   1'b0};
        vecs[11] = '{32'h20,       2'b01, 1'b1, 1'b1, 32'h1,        32'h0,   32'h100, 1'b1};

        // Reset values while rst_n is held low
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h13);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_err", {31'd0, misalign_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_state_req", {31'd0, imem_req}, 32'd0);
        tick();
        m_pc = 32'h0;
        m_instr = 32'h13;

        // Sequential stream 0,4,8
        fetch(32'h33, 0);
        chk("seq_pc0", pc, 32'h0);
        issue(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        fetch(32'h33, 0);
        chk("seq_pc4", pc, 32'h4);
        issue(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        fetch(32'h33, 0);
        chk("seq_pc8", pc, 32'h8);

        // Directed next-PC vectors from a chosen starting PC
        for (int v = 0; v < 12; v++) begin
            issue(2'b10, 1'b0, 1'b0, 32'h0, vecs[v].start, 0);
            fetch($urandom, 0);
            pc_src = vecs[v].src; branch = vecs[v].br; alu_zero = vecs[v].z;
            imm = vecs[v].im; alu_result = vecs[v].alu; stall = 1'b0;
            #1;
            chk($sformatf("vec%0d_err", v), {31'd0, misalign_err}, {31'd0, vecs[v].exp_err});
            tick();
            chk($sformatf("vec%0d_addr", v), imem_addr, vecs[v].exp_pc);
            chk($sformatf("vec%0d_err_after", v), {31'd0, misalign_err}, 32'd0);
            m_pc = vecs[v].exp_pc;
            fetch($urandom, 0);
        end

        // Stall three cycles with a misaligned JALR pending, then one clean advance
        issue(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        fetch(32'h0000_0533, 0);
        issue(2'b10, 1'b0, 1'b0, 32'h0, 32'h3, 3);
        chk("stall_trap", imem_addr, 32'h100);

        // Five-cycle memory wait
        fetch(32'h0040_0093, 5);

        // Reset pulsed mid-FETCH at pc 0x40
        issue(2'b10, 1'b0, 1'b0, 32'h0, 32'h40, 0);
        imem_ready = 1'b0;
        tick();
        chk("midrst_pre_addr", imem_addr, 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_instr", instr, 32'h13);
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        m_pc = 32'h0;
        m_instr = 32'h13;
        fetch(32'h1111_1113, 1);

        // Wrap at top of address space
        issue(2'b10, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 0);
        fetch(32'h33, 0);
        chk("wrap_pc4", pc_plus4, 32'h0);
        issue(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        chk("wrap_addr", imem_addr, 32'h0);
        fetch(32'h33, 0);

        // Randomized traffic against the reference model
        for (int it = 0; it < 300; it++) begin
            logic [1:0]  s;
            logic [31:0] im;
            logic [31:0] alu;
            s   = 2'($urandom_range(0, 3));
            im  = ($urandom_range(0, 3) == 0) ? $urandom : {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            alu = ($urandom_range(0, 3) == 0) ? $urandom : {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 1) ? 2'b01 : 2'b00)};
            issue(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), im, alu, $urandom_range(0, 2));
            fetch($urandom, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
